// File: rtl/dsp_op_sequencer.sv
// Request sequencer for a pipelined DSP48A1 slice: issues operands, tracks them through
// the slice latency and returns results in order through a credit-limited response FIFO.
// Build macro DSP_SEQ_TAG_EN adds a 4-bit tag that travels from request to response.
module dsp_op_sequencer #(
    parameter int LATENCY   = 3,
    parameter int RSP_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [17:0] req_a,
    input  logic [17:0] req_b,
    input  logic [17:0] req_d,
    input  logic [47:0] req_c,
    input  logic [7:0]  req_opmode,
    output logic [17:0] a,
    output logic [17:0] b,
    output logic [17:0] d,
    output logic [47:0] c,
    output logic [7:0]  opmode,
    output logic        ce,
    output logic        dsp_rst,
    input  logic [47:0] p,
    input  logic        carryout,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [47:0] rsp_p,
    output logic        rsp_carryout,
    input  logic        soft_clr,
`ifdef DSP_SEQ_TAG_EN
    input  logic [3:0]  req_tag,
    output logic [3:0]  rsp_tag,
`endif
    output logic        busy
);

    localparam logic [1:0] ST_INIT  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    localparam int CW  = $clog2(RSP_DEPTH + 1);
    localparam int PW  = $clog2(RSP_DEPTH);
    localparam int LCW = $clog2(LATENCY + 1);
`ifdef DSP_SEQ_TAG_EN
    localparam int EW  = 53;
`else
    localparam int EW  = 49;
`endif

    logic [1:0]     state_r;
    logic [1:0]     state_nxt_s;
    logic [LCW-1:0] init_cnt_r;
    logic [CW-1:0]  inflight_r;
    logic [CW-1:0]  fifo_cnt_r;
    logic [CW:0]    occupancy_s;
    logic           issue_r;
    logic [LATENCY-1:0] vpipe_r;
    logic [EW-1:0]  fifo_mem_r [RSP_DEPTH];
    logic [EW-1:0]  push_data_s;
    logic [PW-1:0]  wr_ptr_r;
    logic [PW-1:0]  rd_ptr_r;
    logic           accept_s;
    logic           push_s;
    logic           pop_s;
`ifdef DSP_SEQ_TAG_EN
    logic [3:0]     tag_r;
    logic [3:0]     tpipe_r [LATENCY];
`endif

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
        if (ptr == PW'(RSP_DEPTH - 1)) begin
            return {PW{1'b0}};
        end else begin
            return ptr + PW'(1);
        end
    endfunction

    // Handshake, credit check and next-state decode
    always_comb begin
        occupancy_s = {1'b0, inflight_r} + {1'b0, fifo_cnt_r};
        push_s      = vpipe_r[LATENCY-1];
        pop_s       = (fifo_cnt_r != {CW{1'b0}}) && rsp_ready;
        // Credit covers both buffered and in-flight results so the FIFO can never overflow
        if ((state_r == ST_RUN) && (occupancy_s < (CW+1)'(RSP_DEPTH)) && !soft_clr) begin
            req_ready = 1'b1;
        end else begin
            req_ready = 1'b0;
        end
        accept_s    = req_valid && req_ready;
        state_nxt_s = state_r;
        case (state_r)
            ST_INIT: begin
                if (init_cnt_r == LCW'(LATENCY - 1)) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_INIT;
                end
            end
            ST_RUN: begin
                if (soft_clr) begin
                    state_nxt_s = ST_DRAIN;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (inflight_r == {CW{1'b0}}) begin
                    state_nxt_s = ST_INIT;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            default: state_nxt_s = ST_INIT;
        endcase
    end

    // Sequencer state, INIT cycle count and DSP reset/enable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_INIT;
            init_cnt_r <= {LCW{1'b0}};
            dsp_rst    <= 1'b1;
            ce         <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            if (state_r == ST_INIT) begin
                init_cnt_r <= init_cnt_r + LCW'(1);
            end else begin
                init_cnt_r <= {LCW{1'b0}};
            end
            dsp_rst <= (state_nxt_s == ST_INIT);
            ce      <= 1'b1;
        end
    end

    // Operand registers: load the accepted request, otherwise idle zeros
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a       <= 18'd0;
            b       <= 18'd0;
            d       <= 18'd0;
            c       <= 48'd0;
            opmode  <= 8'h00;
            issue_r <= 1'b0;
        end else if (accept_s) begin
            a       <= req_a;
            b       <= req_b;
            d       <= req_d;
            c       <= req_c;
            opmode  <= req_opmode;
            issue_r <= 1'b1;
        end else begin
            a       <= 18'd0;
            b       <= 18'd0;
            d       <= 18'd0;
            c       <= 48'd0;
            opmode  <= 8'h00;
            issue_r <= 1'b0;
        end
    end

    // Valid shift register aligned with the DSP pipeline so its tail marks a valid P
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vpipe_r <= {LATENCY{1'b0}};
        end else begin
            vpipe_r[0] <= issue_r;
            for (int k = 1; k < LATENCY; k++) begin
                vpipe_r[k] <= vpipe_r[k-1];
            end
        end
    end

`ifdef DSP_SEQ_TAG_EN
    // Tag follows its request alongside the valid pipe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_r <= 4'd0;
            for (int k = 0; k < LATENCY; k++) begin
                tpipe_r[k] <= 4'd0;
            end
        end else begin
            if (accept_s) begin
                tag_r <= req_tag;
            end else begin
                tag_r <= 4'd0;
            end
            tpipe_r[0] <= tag_r;
            for (int k = 1; k < LATENCY; k++) begin
                tpipe_r[k] <= tpipe_r[k-1];
            end
        end
    end

    assign push_data_s = {tpipe_r[LATENCY-1], carryout, p};
    assign rsp_tag     = fifo_mem_r[rd_ptr_r][52:49];
`else
    assign push_data_s = {carryout, p};
`endif

    // In-flight counter: accepted but not yet captured into the FIFO
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_r <= {CW{1'b0}};
        end else begin
            case ({accept_s, push_s})
                2'b10:   inflight_r <= inflight_r + CW'(1);
                2'b01:   inflight_r <= inflight_r - CW'(1);
                default: inflight_r <= inflight_r;
            endcase
        end
    end

    // Response FIFO storage, pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < RSP_DEPTH; k++) begin
                fifo_mem_r[k] <= {EW{1'b0}};
            end
            wr_ptr_r   <= {PW{1'b0}};
            rd_ptr_r   <= {PW{1'b0}};
            fifo_cnt_r <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                fifo_mem_r[wr_ptr_r] <= push_data_s;
                wr_ptr_r             <= next_ptr(wr_ptr_r);
            end
            if (pop_s) begin
                rd_ptr_r <= next_ptr(rd_ptr_r);
            end
            case ({push_s, pop_s})
                2'b10:   fifo_cnt_r <= fifo_cnt_r + CW'(1);
                2'b01:   fifo_cnt_r <= fifo_cnt_r - CW'(1);
                default: fifo_cnt_r <= fifo_cnt_r;
            endcase
        end
    end

    assign rsp_valid    = (fifo_cnt_r != {CW{1'b0}});
    assign rsp_p        = fifo_mem_r[rd_ptr_r][47:0];
    assign rsp_carryout = fifo_mem_r[rd_ptr_r][48];
    assign busy         = !((state_r == ST_RUN) && (inflight_r == {CW{1'b0}}));

endmodule

// File: tb/tb_dsp_op_sequencer.sv
// Scoreboard bench for dsp_op_sequencer with a behavioural DSP slice model; exercises
// init, latency, back-pressure, soft-clear drain, mid-run reset and (optional) tags.
module tb_dsp_op_sequencer;
    localparam int LAT   = 3;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready;
    logic [17:0] req_a, req_b, req_d;
    logic [47:0] req_c;
    logic [7:0]  req_opmode;
    logic [17:0] a, b, d;
    logic [47:0] c;
    logic [7:0]  opmode;
    logic        ce, dsp_rst;
    logic [47:0] p;
    logic        carryout;
    logic        rsp_valid, rsp_ready;
    logic [47:0] rsp_p;
    logic        rsp_carryout;
    logic        soft_clr, busy;
`ifdef DSP_SEQ_TAG_EN
    logic [3:0]  req_tag, rsp_tag;
`endif

    always #5 clk = ~clk;

    dsp_op_sequencer #(.LATENCY(LAT), .RSP_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_d(req_d), .req_c(req_c), .req_opmode(req_opmode),
        .a(a), .b(b), .d(d), .c(c), .opmode(opmode), .ce(ce), .dsp_rst(dsp_rst),
        .p(p), .carryout(carryout),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_p(rsp_p), .rsp_carryout(rsp_carryout),
        .soft_clr(soft_clr),
`ifdef DSP_SEQ_TAG_EN
        .req_tag(req_tag), .rsp_tag(rsp_tag),
`endif
        .busy(busy)
    );

    // Slice function: opmode 8'h1D gives (D+B)*A+C, anything else A*B+C; bit 48 is the carry
    function automatic logic [48:0] dsp_fn(input logic [17:0] fa, input logic [17:0] fb,
                                           input logic [17:0] fd, input logic [47:0] fc,
                                           input logic [7:0] fop);
        logic [48:0] s;
        if (fop == 8'h1D) s = (49'(fd) + 49'(fb)) * 49'(fa) + 49'(fc);
        else              s = 49'(fa) * 49'(fb) + 49'(fc);
        return s;
    endfunction

    logic [48:0] dsp_pipe [LAT];
    always @(posedge clk) begin
        if (dsp_rst) begin
            for (int k = 0; k < LAT; k++) dsp_pipe[k] <= 49'd0;
        end else if (ce) begin
            dsp_pipe[0] <= dsp_fn(a, b, d, c, opmode);
            for (int k = 1; k < LAT; k++) dsp_pipe[k] <= dsp_pipe[k-1];
        end
    end
    assign p        = dsp_pipe[LAT-1][47:0];
    assign carryout = dsp_pipe[LAT-1][48];

    typedef struct packed {
        logic [47:0] p;
        logic        co;
        logic [3:0]  tag;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail = 0;
    int   n_pop = 0;
    int   outstanding = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    // Drive one request cycle; record the expected response when it will be accepted
    task automatic issue(input logic v, input logic [17:0] ia, input logic [17:0] ib,
                         input logic [17:0] id, input logic [47:0] ic, input logic [7:0] op,
                         input logic [3:0] tg, input logic chk_credit, output logic acc);
        exp_t        e;
        logic [48:0] s;
        req_valid = v; req_a = ia; req_b = ib; req_d = id; req_c = ic; req_opmode = op;
`ifdef DSP_SEQ_TAG_EN
        req_tag = tg;
`endif
        #1;
        if (chk_credit) check("req_ready_credit", req_ready, (outstanding < DEPTH) ? 1 : 0);
        acc = v && req_ready;
        if (acc) begin
            s = dsp_fn(ia, ib, id, ic, op);
            e.p = s[47:0]; e.co = s[48]; e.tag = tg;
            exp_q.push_back(e);
            outstanding++;
        end
    endtask

    task automatic rand_issue(input logic v, input logic [3:0] tg, output logic acc);
        issue(v, 18'($urandom), 18'($urandom), 18'($urandom), {16'($urandom), 32'($urandom)},
              ($urandom_range(0, 1) == 1) ? 8'h1D : 8'h05, tg, 1'b1, acc);
    endtask

    task automatic wait_drain(input int budget);
        for (int k = 0; k < budget && exp_q.size() != 0; k++) next_cycle();
        check("drain_done", exp_q.size(), 0);
    endtask

    // Response monitor: pops the scoreboard whenever the DUT hands over a response
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && rsp_valid && rsp_ready) begin
                n_pop++;
                outstanding--;
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_rsp: got p=0x%0h expected no response", rsp_p);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("rsp_p", rsp_p, mon_e.p);
                    check("rsp_carryout", rsp_carryout, mon_e.co);
`ifdef DSP_SEQ_TAG_EN
                    check("rsp_tag", rsp_tag, mon_e.tag);
`endif
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic acc;
        int   hi, early, acc_cnt, pop0, lat;
        logic [3:0] tag_list [3];
        tag_list[0] = 4'hA; tag_list[1] = 4'h5; tag_list[2] = 4'hF;

        rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0; soft_clr = 1'b0;
        req_a = 18'd0; req_b = 18'd0; req_d = 18'd0; req_c = 48'd0; req_opmode = 8'h00;
`ifdef DSP_SEQ_TAG_EN
        req_tag = 4'd0;
`endif
        repeat (3) @(posedge clk);
        #3;
        check("rst_dsp_rst", dsp_rst, 1);
        check("rst_req_ready", req_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_busy", busy, 1);
        check("rst_ce", ce, 0);
        check("rst_a", a, 0);
        check("rst_opmode", opmode, 0);
        check("rst_rsp_p", rsp_p, 0);
        check("rst_rsp_carryout", rsp_carryout, 0);

        // Release reset and measure the INIT window
        next_cycle();
        rst_n = 1'b1;
        hi = 0; early = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (!dsp_rst) break;
            hi++;
            if (req_ready) early++;
        end
        check("init_dsp_rst_cycles", hi, LAT);
        check("init_ready_low", early, 0);
        check("run_req_ready", req_ready, 1);
        check("run_ce", ce, 1);
        check("run_idle_busy", busy, 0);

        // Directed operation with latency measurement
        rsp_ready = 1'b1;
        next_cycle();
        issue(1'b1, 18'd3, 18'd2, 18'd5, 48'd4, 8'h1D, 4'h0, 1'b1, acc);
        check("directed_accept", acc, 1);
        lat = 0;
        for (int k = 1; k <= 12; k++) begin
            next_cycle();
            req_valid = 1'b0;
            @(negedge clk);
            if (rsp_valid) begin
                lat = k;
                break;
            end
        end
        check("directed_latency", lat, 5);
        check("directed_p", rsp_p, 25);
        check("directed_co", rsp_carryout, 0);
        wait_drain(20);

        // Randomised traffic with random back-pressure
        for (int k = 0; k < 300; k++) begin
            next_cycle();
            rsp_ready = ($urandom_range(0, 9) < 6);
            rand_issue(($urandom_range(0, 9) < 7), 4'($urandom), acc);
        end
        next_cycle();
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        wait_drain(40);

        // Full back-pressure: only RSP_DEPTH requests fit
        rsp_ready = 1'b0;
        acc_cnt = 0;
        for (int k = 0; k < 6; k++) begin
            next_cycle();
            rand_issue(1'b1, 4'($urandom), acc);
            if (acc) acc_cnt++;
        end
        check("backpressure_accepts", acc_cnt, DEPTH);
        check("backpressure_ready_low", req_ready, 0);
        pop0 = n_pop;
        next_cycle();
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        wait_drain(30);
        check("backpressure_pops", n_pop - pop0, DEPTH);
        next_cycle();
        rand_issue(1'b1, 4'($urandom), acc);
        check("accept_resumes", acc, 1);
        next_cycle();
        req_valid = 1'b0;
        wait_drain(30);

        // Soft clear with two requests in flight
        next_cycle();
        rand_issue(1'b1, 4'($urandom), acc);
        check("drain_accept0", acc, 1);
        next_cycle();
        rand_issue(1'b1, 4'($urandom), acc);
        check("drain_accept1", acc, 1);
        pop0 = n_pop;
        next_cycle();
        req_valid = 1'b0;
        soft_clr = 1'b1;
        #1;
        check("soft_clr_ready_low", req_ready, 0);
        next_cycle();
        soft_clr = 1'b0;
        hi = 0; early = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (hi > 0 && !dsp_rst) break;
            if (dsp_rst) hi++;
            if (req_ready) early++;
        end
        check("reinit_dsp_rst_cycles", hi, LAT);
        check("drain_no_ready", early, 0);
        check("drain_pops", n_pop - pop0, 2);
        check("drain_ready_back", req_ready, 1);

        // Reset with three buffered responses and one in flight
        rsp_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            next_cycle();
            rand_issue(1'b1, 4'($urandom), acc);
        end
        next_cycle();
        req_valid = 1'b0;
        repeat (3) next_cycle();
        check("pre_reset_rsp_valid", rsp_valid, 1);
        rst_n = 1'b0;
        #1;
        check("midrst_rsp_valid", rsp_valid, 0);
        check("midrst_req_ready", req_ready, 0);
        check("midrst_dsp_rst", dsp_rst, 1);
        check("midrst_busy", busy, 1);
        exp_q.delete();
        outstanding = 0;
        next_cycle();
        rst_n = 1'b1;
        pop0 = n_pop;
        rsp_ready = 1'b1;
        repeat (30) next_cycle();
        check("no_rsp_after_reset", n_pop - pop0, 0);
        check("empty_after_reset", rsp_valid, 0);
        check("ready_after_reinit", req_ready, 1);

`ifdef DSP_SEQ_TAG_EN
        // Tags return in order with their results
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            rand_issue(1'b1, tag_list[k], acc);
            check("tag_accept", acc, 1);
        end
`else
        next_cycle();
        issue(1'b1, 18'd100, 18'd7, 18'd1, 48'hFFFF_FFFF_FFFF, 8'h05, tag_list[0], 1'b1, acc);
        check("post_reset_accept", acc, 1);
`endif
        next_cycle();
        req_valid = 1'b0;
        wait_drain(30);
        check("final_outstanding", outstanding, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
